mul_inc_seq: RTL and testbench
==============================

# mul_inc_seq

Parametrised, sequential successor to the 2-bit combinational multiply/increment cell. It computes the low WIDTH bits of the product a*b with a one-bit-per-cycle shift-add engine. It also computes the increment b + c with carry-out. It sits behind a start/ready request handshake and a valid/ready result handshake, so it can be placed in a pipeline with backpressure. An optional early-exit mode finishes as soon as the remaining multiplier bits are zero.

## Interface
- WIDTH, default 8: operand/result width; legal range ≥ 2. WIDTH = 2 reproduces the original cell's function.
- EARLY_EXIT, default 0: when 1, the multiply terminates once the remaining multiplier bits are all zero.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only on an edge where start=1 and ready=1.
- a  in  WIDTH  multiplicand; sampled on the accept edge.
- b  in  WIDTH  multiplier and increment operand; sampled on the accept edge.
- c  in  1  increment carry-in; sampled on the accept edge.
- ready  out  1  high only in IDLE.
- out_valid  out  1  high only in DONE.
- out_ready  in  1  consumer accepts the result.
- h  out  WIDTH  (a*b) mod 2^WIDTH.
- m  out  WIDTH  (b + c) mod 2^WIDTH.
- m_co  out  1  carry-out of b + c.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On accept: acc←0, a_sh←a, b_sh←b, {m_co,m}←b+c, cnt←0, state→RUN.
- RUN, each edge:
  - if b_sh[0]=1, acc←acc + a_sh, truncated to WIDTH bits; higher bits are discarded.
  - a_sh←a_sh<<1 (truncated); b_sh←b_sh>>1; cnt←cnt+1.
  - Go to DONE when cnt = WIDTH-1, or when EARLY_EXIT=1 and (b_sh>>1)=0.
- DONE:
  - out_valid=1; h, m, m_co held stable.
  - On an edge with out_ready=1, state→IDLE.
- h is driven directly from acc. It is defined only while out_valid=1; it may change during RUN.
- m and m_co are registered at accept and stay stable until the next accept.
- start is ignored in RUN and DONE; no request queueing.
- DONE→IDLE and a new accept cannot share an edge; ready rises the cycle after the handoff.
- The counter is ⌈log2 WIDTH⌉ bits and must not wrap within one operation.

## Timing
- Reset values:
  - state=IDLE.
  - ready=1, out_valid=0.
  - h=0, m=0, m_co=0.
  - acc, a_sh, b_sh and cnt all cleared.
- Reset has priority over every other event, including the accept edge and the DONE handoff.
- Reset mid-RUN or mid-DONE aborts the operation; the result is lost.
- Latency, counted from the accept edge to the edge where out_valid rises:
  - EARLY_EXIT=0: exactly WIDTH cycles.
  - EARLY_EXIT=1: max(1, index of the most-significant set bit of b + 1). b=0 gives 1 cycle.
- Result handshake: the result transfers on the first edge with out_valid=1 and out_ready=1.
- Backpressure has no limit: the block stays in DONE indefinitely with outputs frozen.
- Throughput without backpressure: one operation per latency+2 cycles (accept edge, RUN edges, handoff edge).

## Test plan
- Reset: hold rst 2 cycles with start=1 → ready=1, out_valid=0, h=0, m=0, m_co=0; no accept occurs during reset.
- WIDTH=8, EARLY_EXIT=0, a=3, b=5, c=1 → out_valid rises exactly 8 cycles after accept; h=15, m=6, m_co=0.
- WIDTH=8, a=0xFF, b=0xFF, c=1 → h=0x01, m=0x00, m_co=1. Repeat with WIDTH=2, a=3, b=3, c=1 → h=1, m=0, m_co=1 (matches the original cell).
- EARLY_EXIT=1, WIDTH=8:
  - a=7, b=0x02 → latency 2, h=14.
  - b=0 → latency 1, h=0.
  - b=0x80, a=1 → latency 8, h=0x80.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing start with new operands → out_valid, h, m, m_co unchanged and ready=0; release out_ready → IDLE next cycle, ready=1.
- Reset mid-operation: assert rst on the 3rd RUN edge of a=9, b=9 → IDLE with all outputs 0. Then issue a=4, b=6, c=0 → h=24, m=6, latency 8.

Source files
------------

// File: rtl/mul_inc_seq.sv
// mul_inc_seq: shift-add multiplier (low WIDTH bits of a*b) with a
// registered increment b+c, behind start/ready and valid/ready handshakes.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, priority over everything
//   start      request; accepted when start=1 and ready=1
//   a, b, c    multiplicand, multiplier/increment operand, carry-in
//   ready      high only while idle
//   out_valid  high only while a result is being offered
//   out_ready  consumer takes the result
//   h          (a*b) mod 2^WIDTH, meaningful while out_valid=1
//   m, m_co    b + c and its carry-out, stable until the next accept
module mul_inc_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] m,
  output logic             m_co
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             mco_q, mco_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   inc_sum;
  logic             rest_zero;
  logic             run_fin;

  assign inc_sum = {1'b0, b} + {{WIDTH{1'b0}}, c};

  // Multiplier bits still to be consumed after this edge.
  assign rest_zero = ~|b_sh_q[WIDTH-1:1];

  assign run_fin = (cnt_q == CNT_LAST)
                 | (EARLY_EXIT & rest_zero);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    m_d     = m_q;
    mco_d   = mco_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          a_sh_d  = a;
          b_sh_d  = b;
          m_d     = inc_sum[WIDTH-1:0];
          mco_d   = inc_sum[WIDTH];
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (b_sh_q[0]) begin
          acc_d = acc_q + a_sh_q;
        end
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (run_fin) begin
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // ready rises only after the handoff edge, so a new
        // request can never be accepted on the same edge.
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      m_q     <= '0;
      mco_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      m_q     <= m_d;
      mco_q   <= mco_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready     = ready_q;
  assign out_valid = valid_q;
  assign h         = acc_q;
  assign m         = m_q;
  assign m_co      = mco_q;

endmodule

// File: tb/tb_mul_inc_seq.sv
// tb_mul_inc_seq: three instances (W8, W2, W8 early-exit) on shared
// inputs, checked every cycle against a per-instance behavioural model.
module tb_mul_inc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       c;
  logic       out_ready;

  logic       rdy0, rdy1, rdy2;
  logic       vo0, vo1, vo2;
  logic [7:0] h0, h2, m0, m2;
  logic [1:0] h1, m1;
  logic       co0, co1, co2;

  logic       rdy[3];
  logic       vld[3];
  logic [7:0] hv[3];
  logic [7:0] mv[3];
  logic       cov[3];

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 1'b0;

  always #5 clk = ~clk;

  mul_inc_seq #(.WIDTH(8), .EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c),
    .ready(rdy0), .out_valid(vo0), .out_ready(out_ready),
    .h(h0), .m(m0), .m_co(co0)
  );

  mul_inc_seq #(.WIDTH(2), .EARLY_EXIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .a(a[1:0]), .b(b[1:0]), .c(c),
    .ready(rdy1), .out_valid(vo1), .out_ready(out_ready),
    .h(h1), .m(m1), .m_co(co1)
  );

  mul_inc_seq #(.WIDTH(8), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c),
    .ready(rdy2), .out_valid(vo2), .out_ready(out_ready),
    .h(h2), .m(m2), .m_co(co2)
  );

  assign rdy[0] = rdy0;
  assign rdy[1] = rdy1;
  assign rdy[2] = rdy2;
  assign vld[0] = vo0;
  assign vld[1] = vo1;
  assign vld[2] = vo2;
  assign hv[0]  = h0;
  assign hv[1]  = {6'b0, h1};
  assign hv[2]  = h2;
  assign mv[0]  = m0;
  assign mv[1]  = {6'b0, m1};
  assign mv[2]  = m2;
  assign cov[0] = co0;
  assign cov[1] = co1;
  assign cov[2] = co2;

  // ---------------- reference model ----------------
  function automatic int unsigned w_of(int i);
    return (i == 1) ? 2 : 8;
  endfunction

  function automatic bit ee_of(int i);
    return (i == 2);
  endfunction

  function automatic int unsigned msk(int unsigned w);
    return (32'd1 << w) - 1;
  endfunction

  function automatic int unsigned lat_of(int unsigned w, bit ee,
                                         int unsigned bv);
    int unsigned l = 1;
    if (!ee) return w;
    for (int k = 0; k < int'(w); k++)
      if (((bv >> k) & 1) != 0) l = k + 1;
    return l;
  endfunction

  int unsigned m_left[3];
  bit          m_run[3];
  bit          m_vld[3];
  int unsigned m_h[3];
  int unsigned m_m[3];
  int unsigned m_co[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_run[i]  <= 1'b0;
        m_vld[i]  <= 1'b0;
        m_left[i] <= 0;
        m_h[i]    <= 0;
        m_m[i]    <= 0;
        m_co[i]   <= 0;
      end else if (m_run[i]) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) begin
          m_run[i] <= 1'b0;
          m_vld[i] <= 1'b1;
        end
      end else if (m_vld[i]) begin
        if (out_ready) m_vld[i] <= 1'b0;
      end else if (start) begin
        m_h[i]  <= ((a & msk(w_of(i))) * (b & msk(w_of(i))))
                   & msk(w_of(i));
        m_m[i]  <= ((b & msk(w_of(i))) + c) & msk(w_of(i));
        m_co[i] <= ((b & msk(w_of(i))) + c) >> w_of(i);
        m_left[i] <= lat_of(w_of(i), ee_of(i), b & msk(w_of(i)));
        m_run[i]  <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int unsigned got,
                     input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.ready", i), rdy[i],
            !(m_run[i] || m_vld[i]));
        chk($sformatf("u%0d.out_valid", i), vld[i], m_vld[i]);
        chk($sformatf("u%0d.m", i), mv[i], m_m[i]);
        chk($sformatf("u%0d.m_co", i), cov[i], m_co[i]);
        if (m_vld[i]) chk($sformatf("u%0d.h", i), hv[i], m_h[i]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  int          r_lat[3];
  int unsigned r_h[3];
  int unsigned r_m[3];
  int unsigned r_co[3];

  task automatic wait_idle();
    int n = 0;
    out_ready = 1'b1;
    start     = 1'b0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic cv);
    bit got[3];
    wait_idle();
    a = av;
    b = bv;
    c = cv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got[i]   = 1'b0;
      r_lat[i] = -1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!got[i] && vld[i]) begin
          got[i]   = 1'b1;
          r_lat[i] = k;
          r_h[i]   = hv[i];
          r_m[i]   = mv[i];
          r_co[i]  = cov[i];
        end
      end
    end
    for (int i = 0; i < 3; i++)
      if (!got[i]) chk($sformatf("u%0d.done_timeout", i), 0, 1);
  endtask

  task automatic chk_res(input string tag, input int i,
                         input int unsigned lat, input int unsigned eh,
                         input int unsigned em, input int unsigned eco);
    chk($sformatf("%s.u%0d.latency", tag, i), r_lat[i], lat);
    chk($sformatf("%s.u%0d.h", tag, i), r_h[i], eh);
    chk($sformatf("%s.u%0d.m", tag, i), r_m[i], em);
    chk($sformatf("%s.u%0d.m_co", tag, i), r_co[i], eco);
  endtask

  // ---------------- stimulus ----------------
  int unsigned snap_h[3];
  int unsigned snap_m[3];
  int unsigned snap_co[3];

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b1;
    a         = 8'hA5;
    b         = 8'h3C;
    c         = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst.u%0d.ready", i), rdy[i], 1);
      chk($sformatf("rst.u%0d.out_valid", i), vld[i], 0);
      chk($sformatf("rst.u%0d.h", i), hv[i], 0);
      chk($sformatf("rst.u%0d.m", i), mv[i], 0);
      chk($sformatf("rst.u%0d.m_co", i), cov[i], 0);
    end
    rst   = 1'b0;
    start = 1'b0;

    run_op(8'd3, 8'd5, 1'b1);
    chk_res("op35", 0, 8, 15, 6, 0);
    chk_res("op35", 1, 2, 3, 2, 0);
    chk_res("op35", 2, 3, 15, 6, 0);

    run_op(8'hFF, 8'hFF, 1'b1);
    chk_res("opff", 0, 8, 1, 0, 1);
    chk_res("opff", 1, 2, 1, 0, 1);
    chk_res("opff", 2, 8, 1, 0, 1);

    run_op(8'd7, 8'd2, 1'b0);
    chk_res("op72", 0, 8, 14, 2, 0);
    chk_res("op72", 1, 2, 2, 2, 0);
    chk_res("op72", 2, 2, 14, 2, 0);

    run_op(8'h55, 8'h00, 1'b0);
    chk_res("opb0", 0, 8, 0, 0, 0);
    chk_res("opb0", 1, 2, 0, 0, 0);
    chk_res("opb0", 2, 1, 0, 0, 0);

    run_op(8'h01, 8'h80, 1'b1);
    chk_res("op80", 0, 8, 8'h80, 8'h81, 0);
    chk_res("op80", 1, 2, 0, 1, 0);
    chk_res("op80", 2, 8, 8'h80, 8'h81, 0);

    // backpressure: hold the result while start is pulsed
    wait_idle();
    out_ready = 1'b0;
    a = 8'hC3;
    b = 8'h85;
    c = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(vld[0] && vld[1] && vld[2]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("bp.valid_timeout", 0, 1);
    chk("bp.u0.h", hv[0], 8'h4F);
    chk("bp.u0.m", mv[0], 8'h86);
    for (int i = 0; i < 3; i++) begin
      snap_h[i]  = hv[i];
      snap_m[i]  = mv[i];
      snap_co[i] = cov[i];
    end
    repeat (5) begin
      start = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp.u%0d.valid", i), vld[i], 1);
        chk($sformatf("bp.u%0d.ready", i), rdy[i], 0);
        chk($sformatf("bp.u%0d.h", i), hv[i], snap_h[i]);
        chk($sformatf("bp.u%0d.m", i), mv[i], snap_m[i]);
        chk($sformatf("bp.u%0d.m_co", i), cov[i], snap_co[i]);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp.rel.u%0d.valid", i), vld[i], 0);
      chk($sformatf("bp.rel.u%0d.ready", i), rdy[i], 1);
    end

    // reset on the third RUN edge of a=9, b=9
    wait_idle();
    a = 8'd9;
    b = 8'd9;
    c = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mrst.u%0d.ready", i), rdy[i], 1);
      chk($sformatf("mrst.u%0d.valid", i), vld[i], 0);
      chk($sformatf("mrst.u%0d.h", i), hv[i], 0);
      chk($sformatf("mrst.u%0d.m", i), mv[i], 0);
      chk($sformatf("mrst.u%0d.m_co", i), cov[i], 0);
    end
    run_op(8'd4, 8'd6, 1'b0);
    chk_res("op46", 0, 8, 24, 6, 0);
    chk_res("op46", 1, 2, 0, 2, 0);
    chk_res("op46", 2, 3, 24, 6, 0);

    // randomized traffic with backpressure and sporadic reset
    for (int k = 0; k < 800; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) == 0);
      a     = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 8'h00;
        1:       b = 8'h01 << $urandom_range(0, 7);
        default: b = 8'($urandom);
      endcase
      c         = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    rst = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
